// File: rtl/joystick_debounce_pkg.sv
// Shared definitions for the joystick debouncer.
//   JOY_* : bit indices inside a 5-bit joystick vector {fire, left, right, down, up}
//   joy_t : 5-bit joystick vector, index 0 = fire
//   cnt_action_e : per-tick decision taken by each debounce_bit counter
package joystick_debounce_pkg;

  localparam int unsigned JOY_FIRE  = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_RIGHT = 2;
  localparam int unsigned JOY_DOWN  = 3;
  localparam int unsigned JOY_UP    = 4;
  localparam int unsigned JOY_W     = 5;

  typedef logic [0:JOY_W-1] joy_t;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_CLEAR,
    CNT_INC,
    CNT_FLIP
  } cnt_action_e;

endpackage

// File: rtl/joystick_debounce_bit.sv
// Single-pin debouncer: two-flop synchroniser followed by a tick-qualified
// persistence counter and the accepted (active-high) stable state.
//   clk, reset : system clock, asynchronous active-high reset
//   sample_en  : single-cycle debounce tick
//   pin_n      : raw active-low pin, asynchronous to clk
//   st         : debounced active-high state
module debounce_bit
  import joystick_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic pin_n,
  output logic st
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  cnt_action_e      action;

  // Synchroniser runs every clock; released (idle-high) during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pin_n;
      sync2 <= sync1;
    end
  end

  // The counter only reaches CNT_MAX while the input disagrees with st,
  // and the flip clears it, so it can never wrap.
  always_comb begin
    action = CNT_HOLD;
    if (sample_en) begin
      if (~sync2 == st)
        action = CNT_CLEAR;
      else if (cnt == CNT_MAX)
        action = CNT_FLIP;
      else
        action = CNT_INC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      st  <= 1'b0;
    end else begin
      case (action)
        CNT_CLEAR: cnt <= '0;
        CNT_INC:   cnt <= cnt + CNT_W'(1);
        CNT_FLIP: begin
          cnt <= '0;
          st  <= ~st;
        end
        default:   cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/joystick_debounce.sv
// Two-port joystick debouncer with port swap.
//   clk, reset : system clock, asynchronous active-high reset
//   sample_en  : debounce tick (clock enable)
//   fa_n, fb_n : raw active-low pins {fire, left, right, down, up}
//   swap       : 1 routes port B to joy1 and port A to joy2
//   joy1, joy2 : registered debounced active-high joystick vectors
//   change     : one-cycle pulse when any debounced bit toggles
module joystick_debounce
  import joystick_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [0:JOY_W-1] fa_n,
  input  logic [0:JOY_W-1] fb_n,
  input  logic             swap,
  output logic [0:JOY_W-1] joy1,
  output logic [0:JOY_W-1] joy2,
  output logic             change
);

  joy_t st_a;
  joy_t st_b;
  joy_t st_a_q;
  joy_t st_b_q;

  for (genvar i = 0; i < JOY_W; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .CNT_W         (CNT_W)
    ) u_a (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en),
      .pin_n    (fa_n[i]),
      .st       (st_a[i])
    );

    debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .CNT_W         (CNT_W)
    ) u_b (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en),
      .pin_n    (fb_n[i]),
      .st       (st_b[i])
    );
  end

  // change compares against a delayed copy of st rather than the routed
  // outputs, so a swap never produces a pulse; it lines up with joy1/joy2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy1   <= '0;
      joy2   <= '0;
      st_a_q <= '0;
      st_b_q <= '0;
      change <= 1'b0;
    end else begin
      joy1   <= swap ? st_b : st_a;
      joy2   <= swap ? st_a : st_b;
      st_a_q <= st_a;
      st_b_q <= st_b;
      change <= |({st_a, st_b} ^ {st_a_q, st_b_q});
    end
  end

endmodule

// File: tb/tb_joystick_debounce.sv
module tb_joystick_debounce;

  localparam int TICKS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en = 1'b0;
  logic [0:4] fa_n;
  logic [0:4] fb_n;
  logic       swap;
  logic [0:4] joy1;
  logic [0:4] joy2;
  logic       change;

  int errors = 0;
  int checks = 0;
  int div = 0;

  joystick_debounce #(
    .DEBOUNCE_TICKS(TICKS),
    .CNT_W         (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .fa_n     (fa_n),
    .fb_n     (fb_n),
    .swap     (swap),
    .joy1     (joy1),
    .joy2     (joy2),
    .change   (change)
  );

  always #5 clk = ~clk;

  // One tick every 4th clock, changed away from the sampling edge.
  always @(negedge clk) begin
    div = (div + 1) % 4;
    sample_en = (div == 0);
  end

  // Reference model: a pin is accepted once the last TICKS tick samples of its
  // synchronised level all disagree with the accepted state.
  logic [9:0]       raw_n;
  logic [9:0]       ms1, ms2, mst, mst_prev;
  logic [TICKS-2:0] mhist [10];
  int               mhcnt [10];
  logic [0:4]       m_joy1, m_joy2;
  logic             m_change;

  always_comb begin
    raw_n = '1;
    for (int i = 0; i < 5; i++) begin
      raw_n[i]     = fa_n[i];
      raw_n[i + 5] = fb_n[i];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms1      <= '1;
      ms2      <= '1;
      mst      <= '0;
      mst_prev <= '0;
      m_joy1   <= '0;
      m_joy2   <= '0;
      m_change <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        mhist[i] <= '0;
        mhcnt[i] <= 0;
      end
    end else begin
      ms1 <= raw_n;
      ms2 <= ms1;
      if (sample_en) begin
        for (int i = 0; i < 10; i++) begin
          mhist[i] <= {mhist[i][TICKS-3:0], ~ms2[i]};
          if (mhcnt[i] < TICKS) mhcnt[i] <= mhcnt[i] + 1;
          if ((~ms2[i] != mst[i]) && (mhcnt[i] >= TICKS - 1) &&
              (mhist[i] == {(TICKS-1){~ms2[i]}}))
            mst[i] <= ~mst[i];
        end
      end
      mst_prev <= mst;
      m_change <= (mst != mst_prev);
      for (int j = 0; j < 5; j++) begin
        m_joy1[j] <= swap ? mst[j + 5] : mst[j];
        m_joy2[j] <= swap ? mst[j] : mst[j + 5];
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({joy1, joy2, change} !== 11'b0) begin
        errors++;
        $display("FAIL reset_hold: joy1=%b joy2=%b change=%b, want all 0", joy1, joy2, change);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({joy1, joy2, change} !== 11'b0 ||
          {joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: joy1=%b joy2=%b change=%b, want all 0", c, joy1, joy2, change);
      end
    end
  endtask

  task automatic test_fire_latency();
    int lat = -1;
    int pulses = 0;
    fa_n[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (change) pulses++;
      if (lat < 0 && joy1 == 5'b10000) lat = c;
      checks++;
      if ({joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL fire_model cyc%0d: got %b/%b/%b want %b/%b/%b", c, joy1, joy2, change, m_joy1, m_joy2, m_change);
      end
    end
    checks++;
    if (lat < 16 || lat > 19) begin
      errors++;
      $display("FAIL fire_latency: got %0d cycles, want 16..19", lat);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL fire_change: got %0d high cycles, want 1", pulses);
    end
    fa_n[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL fire_release cyc%0d: got %b/%b/%b want %b/%b/%b", c, joy1, joy2, change, m_joy1, m_joy2, m_change);
      end
    end
  endtask

  task automatic test_glitch();
    fa_n[4] = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (c == 8) fa_n[4] = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (joy1 !== 5'b0 || change !== 1'b0 ||
          {joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL glitch cyc%0d: joy1=%b change=%b, want 00000/0", c, joy1, change);
      end
    end
  endtask

  task automatic test_swap();
    fb_n = 5'b01110;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL swap_settle cyc%0d: got %b/%b/%b want %b/%b/%b", c, joy1, joy2, change, m_joy1, m_joy2, m_change);
      end
    end
    checks++;
    if (joy2 !== 5'b10001 || joy1 !== 5'b00000) begin
      errors++;
      $display("FAIL swap_before: joy1=%b joy2=%b, want 00000/10001", joy1, joy2);
    end
    swap = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (joy1 !== 5'b10001 || joy2 !== 5'b00000 || change !== 1'b0) begin
      errors++;
      $display("FAIL swap_after: joy1=%b joy2=%b change=%b, want 10001/00000/0", joy1, joy2, change);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (change !== 1'b0 || {joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL swap_hold cyc%0d: got %b/%b/%b want %b/%b/%b", c, joy1, joy2, change, m_joy1, m_joy2, m_change);
      end
    end
    swap = 1'b0;
    fb_n = 5'b11111;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL swap_release cyc%0d: got %b/%b/%b want %b/%b/%b", c, joy1, joy2, change, m_joy1, m_joy2, m_change);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    int lat = -1;
    fa_n[1] = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (joy1 !== 5'b0) begin
      errors++;
      $display("FAIL midcount_pre: joy1=%b, want 00000", joy1);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); @(negedge clk);
      if (lat < 0 && joy1[1] === 1'b1) lat = c;
      checks++;
      if ({joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL midcount_model cyc%0d: got %b/%b/%b want %b/%b/%b", c, joy1, joy2, change, m_joy1, m_joy2, m_change);
      end
    end
    checks++;
    if (lat < 16 || lat > 19) begin
      errors++;
      $display("FAIL midcount_latency: got %0d cycles after release, want 16..19", lat);
    end
    fa_n[1] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_all_low();
    int first = -1;
    int pulses = 0;
    fa_n = 5'b00000;
    fb_n = 5'b00000;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); @(negedge clk);
      if (change) pulses++;
      if (first < 0 && {joy1, joy2} != 10'b0) begin
        first = c;
        checks++;
        if ({joy1, joy2} !== 10'h3ff) begin
          errors++;
          $display("FAIL all_low_same_cycle: joy1=%b joy2=%b, want 11111/11111", joy1, joy2);
        end
      end
      checks++;
      if ({joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
        errors++;
        $display("FAIL all_low_model cyc%0d: got %b/%b/%b want %b/%b/%b", c, joy1, joy2, change, m_joy1, m_joy2, m_change);
      end
    end
    checks++;
    if (pulses != 1 || first < 0) begin
      errors++;
      $display("FAIL all_low_change: got %0d pulses (first=%0d), want 1", pulses, first);
    end
    fa_n = 5'b11111;
    fb_n = 5'b11111;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      int p = $urandom_range(0, 9);
      int hold = $urandom_range(1, 24);
      if (p < 5) fa_n[p] = ~fa_n[p];
      else       fb_n[p - 5] = ~fb_n[p - 5];
      if ($urandom_range(0, 7) == 0) swap = ~swap;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if ({joy1, joy2, change} !== {m_joy1, m_joy2, m_change}) begin
          errors++;
          $display("FAIL random it%0d: got %b/%b/%b want %b/%b/%b", it, joy1, joy2, change, m_joy1, m_joy2, m_change);
        end
      end
    end
  endtask

  initial begin
    fa_n  = 5'b11111;
    fb_n  = 5'b11111;
    swap  = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_fire_latency();
    test_glitch();
    test_swap();
    test_reset_mid_count();
    test_all_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joystick_debounce.md
JOYSTICK_DEBOUNCE -- requirements
Module: joystick_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 16: number of consecutive sample_en ticks a changed input must persist before it is accepted (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8: debounce counter width; it SHALL hold DEBOUNCE_TICKS-1.
REQ-003 clk  input  1  system clock; the single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_en  input  1  single-cycle debounce tick; the 3 MHz clock enable in the system.
REQ-006 fa_n  input  [0:4]  raw port A pins, active-low, ordered {fire, left, right, down, up}; asynchronous to clk.
REQ-007 fb_n  input  [0:4]  raw port B pins, active-low, same order as fa_n.
REQ-008 swap  input  1  synchronous control; when 1, port B drives joy1 and port A drives joy2.
REQ-009 joy1  output  [0:4]  debounced joystick 1, active-high, same bit order; feeds the mainboard joy1 input.
REQ-010 joy2  output  [0:4]  debounced joystick 2, active-high, same bit order; feeds the mainboard joy2 input.
REQ-011 change  output  1  one-cycle pulse when any debounced bit of either port toggles.

Function
REQ-012 Each of the 10 raw pins SHALL pass through a two-flop synchroniser clocked on every clk edge, not gated by sample_en.
REQ-013 Each bit SHALL hold a stable state st (active-high) and a counter cnt.
REQ-014 On a clk edge with sample_en=1 and inverted synchronised input equal to st, cnt SHALL clear to 0.
REQ-015 On a clk edge with sample_en=1, input differing from st and cnt < DEBOUNCE_TICKS-1, cnt SHALL increment by 1.
REQ-016 On a clk edge with sample_en=1, input differing from st and cnt = DEBOUNCE_TICKS-1, st SHALL invert and cnt SHALL clear to 0.
REQ-017 With sample_en=0, st and cnt SHALL hold; a glitch that reverts between ticks SHALL be invisible.
REQ-018 With DEBOUNCE_TICKS=1, st SHALL follow the synchronised input on the first sample_en tick at which they differ.
REQ-019 cnt SHALL never wrap; it SHALL saturate by construction per REQ-016.
REQ-020 joy1/joy2 SHALL be registered: joy1 <= swap ? stB : stA and joy2 <= swap ? stA : stB, updated every clk edge.
REQ-021 Latency from a pin edge to the joy output SHALL be 2 synchroniser cycles, plus DEBOUNCE_TICKS qualifying ticks, plus 1 output register cycle.
REQ-022 A swap change SHALL appear on joy1/joy2 one clk after it is sampled, without debounce, and SHALL NOT assert change.
REQ-023 change SHALL be registered and SHALL assert for exactly one cycle on the edge after any st bit toggles; simultaneous toggles of several bits SHALL produce a single pulse.

Reset
REQ-024 While reset=1: synchroniser flops SHALL be 1 (released), all st 0, all cnt 0, joy1=joy2=5'b00000, change=0.
REQ-025 Reset asserted mid-count SHALL discard the partial count; after release, a held pin SHALL need the full REQ-021 latency again.

Structure
REQ-026 One sub-module, debounce_bit (synchroniser, counter and st for a single pin), SHALL be instantiated 10 times.
REQ-027 The shared package SHALL hold the joystick bit-index constants (JOY_FIRE=0, JOY_LEFT=1, JOY_RIGHT=2, JOY_DOWN=3, JOY_UP=4) and the 5-bit joystick vector typedef.
REQ-028 The mainboard-side top SHALL drop its inline inversion of the port pins and instantiate this block instead.

Verification (DEBOUNCE_TICKS=4, sample_en every 4th clk)
REQ-029 Reset, then release with all pins 1 -> joy1=joy2=0 and change=0 for 100 cycles.
REQ-030 fa_n[0] driven to 0 and held -> joy1=5'b10000 exactly 2 + 4 ticks + 1 clk after the edge; change pulses once, 1 cycle wide.
REQ-031 fa_n[4] low for 2 ticks then high -> joy1 stays 0 and change never asserts.
REQ-032 fb_n=5'b01110 held, then swap=1 -> joy2=5'b10001 and joy1=0; after swap, joy1=5'b10001 one clk later; no change pulse on the swap.
REQ-033 fa_n[1] low for 3 ticks, reset pulsed, pin kept low -> joy1=0 until a full 4 fresh ticks plus pipeline delay have passed.
REQ-034 fa_n and fb_n all driven low on the same edge -> all 10 bits assert on the same cycle and change pulses once.
